network_interface: RTL

NETWORK_INTERFACE -- requirements
Module: network_interface

---
 rtl/network_interface.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/network_interface.sv
// Network interface: core-side transmit FIFO feeding a router local port,
// plus a single-entry receive buffer. Optional NI_STATS_EN adds tx/rx counters.
module network_interface #(
    parameter int PL        = 8,
    parameter int CS        = 2,
    parameter int DEPTH     = 4,
    parameter int STALL_MAX = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CS-1:0]       router_X,
    input  logic [CS-1:0]       router_Y,
    input  logic                core_valid,
    input  logic [CS-1:0]       core_dest_x,
    input  logic [CS-1:0]       core_dest_y,
    input  logic [PL-2-2*CS:0]  core_payload,
    output logic                core_ready,
    output logic [0:PL-1]       data_out,
    input  logic                availability_in,
    input  logic [0:PL-1]       data_in,
    output logic                availability_out,
    output logic                rx_valid,
    output logic [PL-2-2*CS:0]  rx_payload,
    output logic                rx_misrouted,
    input  logic                rx_ack,
    output logic                stall_err
`ifdef NI_STATS_EN
    ,
    output logic [15:0]         tx_count,
    output logic [15:0]         rx_count
`endif
);

    localparam int PW = PL - 1 - 2 * CS;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [0:PL-1]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_d;
    logic [SW-1:0]   stall_cnt;
    logic [0:PL-1]   push_flit;
    logic [0:PL-1]   dout_d;
    logic            push;
    logic            pop;
    logic            stall_inc;
    logic            rx_take;
    logic [2*CS-1:0] rx_dest;

    assign core_ready       = rst_n & (count != CW'(DEPTH));
    assign push             = core_valid & core_ready;
    assign push_flit        = {1'b1, core_dest_x, core_dest_y, core_payload};
    assign availability_out = ~rx_valid | rx_ack;
    assign rx_take          = data_in[0] & availability_out;
    assign rx_dest          = data_in[1 +: 2*CS];

    // Next-state, next output flit and FIFO pop decision
    always_comb begin
        state_d   = state_q;
        dout_d    = data_out;
        pop       = 1'b0;
        stall_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                dout_d = '0;
                if (count != '0) begin
                    state_d = SEND;
                    dout_d  = mem[rd_ptr];
                end
            end
            SEND, STALL: begin
                if (availability_in) begin
                    pop = 1'b1;
                    if (count > CW'(1)) begin
                        state_d = SEND;
                        dout_d  = mem[rd_ptr + AW'(1)];
                    end else if (push) begin
                        state_d = SEND;
                        dout_d  = push_flit;
                    end else begin
                        state_d = IDLE;
                        dout_d  = '0;
                    end
                end else begin
                    state_d   = STALL;
                    stall_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                dout_d  = '0;
            end
        endcase
    end

    // FIFO occupancy update
    always_comb begin
        count_d = count;
        unique case ({push, pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_flit;
    end

    // Transmit state, pointers and held output flit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_out <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state_q  <= state_d;
            data_out <= dout_d;
            count    <= count_d;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Stall counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (pop) begin
            stall_cnt <= '0;
        end else if (stall_inc) begin
            if (stall_cnt != SW'(STALL_MAX)) stall_cnt <= stall_cnt + SW'(1);
            if (stall_cnt >= SW'(STALL_MAX - 1)) stall_err <= 1'b1;
        end
    end

    // Receive buffer: one packet held until the core acknowledges it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid     <= 1'b0;
            rx_payload   <= '0;
            rx_misrouted <= 1'b0;
        end else if (rx_take) begin
            rx_valid     <= 1'b1;
            rx_payload   <= data_in[1+2*CS +: PW];
            rx_misrouted <= (rx_dest != {router_X, router_Y});
        end else if (rx_ack & rx_valid) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef NI_STATS_EN
    // Saturating transfer counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            if (pop && tx_count != 16'hFFFF) tx_count <= tx_count + 16'd1;
            if (rx_take && rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
        end
    end
`endif

endmodule
